// File: rtl/sel_upd_ctrl_if.sv
// Signal bundle between the fetch-side predictors, the chooser controller and sel_tab.
// The controller owns the slave view; the surrounding environment uses the master view.
interface sel_upd_ctrl_if #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Predict path
  logic             pred_valid;
  logic             pred_ready;
  logic [IDX_W-1:0] pred_idx;
  logic             p_local;
  logic             p_global;
  logic             final_vld;
  logic             final_pred;

  // Resolve path
  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic             flush;
  logic [CNT_W-1:0] q_count;

  // sel_tab access
  logic [IDX_W-1:0] addr;
  logic             up_en;
  logic [1:0]       up_data;
  logic [1:0]       rd_data;

  modport slave (
    input  pred_valid, pred_idx, p_local, p_global,
    input  res_valid, res_taken, flush, rd_data,
    output pred_ready, final_vld, final_pred,
    output res_ready, q_count, addr, up_en, up_data
  );

  modport master (
    output pred_valid, pred_idx, p_local, p_global,
    output res_valid, res_taken, flush, rd_data,
    input  pred_ready, final_vld, final_pred,
    input  res_ready, q_count, addr, up_en, up_data
  );
endinterface

// File: rtl/sel_upd_ctrl.sv
// Tournament chooser control: selects local/global prediction from sel_tab, queues in-flight
// branches, and read-modify-writes the 2-bit chooser counter when the oldest branch resolves.
//
// Handshake: a transfer happens on a rising edge where valid && ready; ready depends on
// valid-independent state only plus the priority rule (resolve wins over predict), and a
// flush in the same cycle withdraws both readies so the flush alone takes effect.
module sel_upd_ctrl #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  sel_upd_ctrl_if.slave bus,
  output logic [1:0]    dbg_state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  state_e           state_q, state_d;

  // Record layout: {idx, local_dir, global_dir}
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_l_q, upd_g_q, taken_q;
  logic [1:0]       ctr_q;
  logic             final_vld_q, final_pred_q;

  logic             push, pop, empty, full;
  logic [REC_W-1:0] head;
  logic [IDX_W-1:0] head_idx;
  logic             head_l, head_g;
  logic [1:0]       new_ctr;
  logic [IDX_W-1:0] addr;
  logic             pred_ready, res_ready, up_en;
  logic [1:0]       up_data;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign head_idx = head[REC_W-1:2];
  assign head_l   = head[1];
  assign head_g   = head[0];

  // Only reached when the two predictors disagreed, so exactly one of them was right.
  always_comb begin
    new_ctr = ctr_q;
    if (upd_g_q == taken_q) begin
      if (ctr_q != 2'b11) new_ctr = ctr_q + 2'd1;
    end else begin
      if (ctr_q != 2'b00) new_ctr = ctr_q - 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr       = bus.pred_idx;
    pred_ready = 1'b0;
    res_ready  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    up_en      = 1'b0;
    up_data    = 2'b00;
    case (state_q)
      IDLE: begin
        addr = bus.pred_idx;
        if (!bus.flush) begin
          if (bus.res_valid && !empty) begin
            res_ready = 1'b1;
            pop       = 1'b1;
            if (head_l != head_g) state_d = RD;
          end else if (bus.pred_valid && !full) begin
            pred_ready = 1'b1;
            push       = 1'b1;
          end
        end
      end
      RD: begin
        addr    = upd_idx_q;
        state_d = bus.flush ? IDLE : WR;
      end
      WR: begin
        // The write in flight is allowed to finish even under flush.
        addr    = upd_idx_q;
        up_en   = 1'b1;
        up_data = new_ctr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.pred_idx, bus.p_local, bus.p_global};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      upd_idx_q    <= '0;
      upd_l_q      <= 1'b0;
      upd_g_q      <= 1'b0;
      taken_q      <= 1'b0;
      ctr_q        <= 2'b00;
      final_vld_q  <= 1'b0;
      final_pred_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      final_vld_q <= push;
      if (push) final_pred_q <= bus.rd_data[1] ? bus.p_global : bus.p_local;

      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        count_q  <= count_q + CNT_W'(1);
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q  <= count_q - CNT_W'(1);
      end

      if (pop) begin
        upd_idx_q <= head_idx;
        upd_l_q   <= head_l;
        upd_g_q   <= head_g;
        taken_q   <= bus.res_taken;
      end

      if (state_q == RD) ctr_q <= bus.rd_data;
    end
  end

  assign bus.pred_ready = pred_ready;
  assign bus.res_ready  = res_ready;
  assign bus.final_vld  = final_vld_q;
  assign bus.final_pred = final_pred_q;
  assign bus.q_count    = count_q;
  assign bus.addr       = addr;
  assign bus.up_en      = up_en;
  assign bus.up_data    = up_data;
  assign dbg_state_o    = state_q;

endmodule
